// File: rtl/fft_bitrev_stream_if.sv
// rtl/fft_bitrev_stream_if.sv - Input/output stream bundle of the FFT bit-reversal reorder buffer
// The slave modport is the reorder buffer; the master modport is the producer/consumer side.
interface fft_bitrev_stream_if #(
    parameter int WIDTH = 13
);
    logic                    din_valid;
    logic                    din_ready;
    logic signed [WIDTH-1:0] din_re;
    logic signed [WIDTH-1:0] din_im;
    logic                    din_last;

    logic                    dout_valid;
    logic                    dout_ready;
    logic signed [WIDTH-1:0] dout_re;
    logic signed [WIDTH-1:0] dout_im;
    logic                    dout_sof;
    logic                    dout_last;

    logic                    frame_err;

    modport master (
        output din_valid, din_re, din_im, din_last, dout_ready,
        input  din_ready, dout_valid, dout_re, dout_im, dout_sof, dout_last, frame_err
    );

    modport slave (
        input  din_valid, din_re, din_im, din_last, dout_ready,
        output din_ready, dout_valid, dout_re, dout_im, dout_sof, dout_last, frame_err
    );
endinterface

// File: rtl/fft_bitrev_stream.sv
// rtl/fft_bitrev_stream.sv - Ping-pong bit-reversal reorder buffer for the serial FFT input
// Writes sample k to bitrev(k) in the filling bank and streams the full bank out linearly.
module fft_bitrev_stream #(
    parameter int N     = 512,
    parameter int LOG2N = 9,
    parameter int WIDTH = 13
) (
    input  logic                      clk,
    input  logic                      rstn,
    fft_bitrev_stream_if.slave        bus
);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    typedef logic [2*WIDTH-1:0] word_t;

    // Both banks in one array; the MSB of the address selects the bank.
    word_t mem [0:2*N-1];

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_sof_q, dout_sof_d;
    logic             dout_last_q, dout_last_d;
    logic             frame_err_q, frame_err_d;
    word_t            dout_data_q;

    logic             din_ready;
    logic             wr_fire;
    logic             wr_end;
    logic             rd_end;
    logic             load;
    logic [LOG2N:0]   wr_addr;
    logic [LOG2N:0]   rd_addr;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    always_comb begin
        din_ready = !full_q[wr_bank_q];
        wr_fire   = bus.din_valid && din_ready;
        wr_end    = (wr_cnt_q == LAST_IDX);
        rd_end    = (rd_cnt_q == LAST_IDX);
        load      = full_q[rd_bank_q] && (!dout_valid_q || bus.dout_ready);
        wr_addr   = {wr_bank_q, bitrev(wr_cnt_q)};
        rd_addr   = {rd_bank_q, rd_cnt_q};
    end

    // Writer sets full only on a non-full bank, reader clears only a full one,
    // so the two updates never collide on the same bit.
    always_comb begin
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        full_d       = full_q;
        dout_valid_d = dout_valid_q;
        dout_sof_d   = dout_sof_q;
        dout_last_d  = dout_last_q;
        frame_err_d  = frame_err_q;

        if (wr_fire) begin
            wr_cnt_d    = wr_cnt_q + LOG2N'(1);
            frame_err_d = frame_err_q | (bus.din_last != wr_end);
            if (wr_end) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_cnt_d          = '0;
            end
        end

        if (load) begin
            rd_cnt_d     = rd_cnt_q + LOG2N'(1);
            dout_valid_d = 1'b1;
            dout_sof_d   = (rd_cnt_q == '0);
            dout_last_d  = rd_end;
            if (rd_end) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
                rd_cnt_d          = '0;
            end
        end else if (bus.dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            full_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_sof_q   <= 1'b0;
            dout_last_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            full_q       <= full_d;
            dout_valid_q <= dout_valid_d;
            dout_sof_q   <= dout_sof_d;
            dout_last_q  <= dout_last_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= {bus.din_re, bus.din_im};
        end
    end

    // The output register doubles as the RAM read register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout_data_q <= '0;
        end else if (load) begin
            dout_data_q <= mem[rd_addr];
        end
    end

    assign bus.din_ready  = din_ready;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_re    = dout_data_q[2*WIDTH-1:WIDTH];
    assign bus.dout_im    = dout_data_q[WIDTH-1:0];
    assign bus.dout_sof   = dout_sof_q;
    assign bus.dout_last  = dout_last_q;
    assign bus.frame_err  = frame_err_q;
endmodule
